// File: rtl/npc_bus_pkg.sv
// npc_bus_pkg: shared bus types and constants for the NPC memory arbiter
package npc_bus_pkg;
    localparam int XLEN = 32;
    localparam int WMASK_W = 4;
    localparam logic [XLEN-1:0] RESET_ADDR = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;
    typedef struct packed {
        logic [XLEN-1:0]    addr;
        logic               wen;
        logic [XLEN-1:0]    wdata;
        logic [WMASK_W-1:0] wmask;
    } req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU/LSU request-response ports plus the shared memory port
interface mem_arbiter_if;
    import npc_bus_pkg::*;
    logic               ifu_req_valid, ifu_req_ready;
    logic [XLEN-1:0]    ifu_req_addr;
    logic               ifu_rsp_valid, ifu_rsp_err;
    logic [XLEN-1:0]    ifu_rsp_rdata;
    logic               lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [XLEN-1:0]    lsu_req_addr, lsu_req_wdata;
    logic [WMASK_W-1:0] lsu_req_wmask;
    logic               lsu_rsp_valid, lsu_rsp_err;
    logic [XLEN-1:0]    lsu_rsp_rdata;
    logic               mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [XLEN-1:0]    mem_addr, mem_wdata, mem_rsp_rdata;
    logic [WMASK_W-1:0] mem_wmask;
    modport slave (
        input  ifu_req_valid, ifu_req_addr, lsu_req_valid, lsu_req_addr, lsu_req_wen,
               lsu_req_wdata, lsu_req_wmask, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
               lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
    modport master (
        output ifu_req_valid, ifu_req_addr, lsu_req_valid, lsu_req_addr, lsu_req_wen,
               lsu_req_wdata, lsu_req_wmask, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
               lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/arb_rr2.sv
// arb_rr2: 2-way IFU/LSU picker, fixed LSU priority or round-robin on ties
module arb_rr2
    import npc_bus_pkg::*;
#(
    parameter bit LSU_PRIO = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   ifu_v_i,
    input  logic   lsu_v_i,
    input  logic   en_i,
    output owner_e owner_o,
    output logic   gnt_o
);
    owner_e last_q, last_d;
    always_comb begin
        owner_o = (lsu_v_i && (!ifu_v_i || LSU_PRIO || last_q == OWN_IFU)) ? OWN_LSU : OWN_IFU;
        gnt_o   = en_i && (ifu_v_i || lsu_v_i);
        last_d  = gnt_o ? owner_o : last_q;
    end
    // pointer starts at LSU so the first tie goes to IFU
    always_ff @(posedge clk) begin
        last_q <= rst ? OWN_LSU : last_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction at a time
module mem_arbiter
    import npc_bus_pkg::*;
#(
    parameter bit          LSU_PRIO = 1'b1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic clk,
    input  logic rst,
    mem_arbiter_if.slave bus
);
    localparam logic [15:0] TO = 16'(TIMEOUT);
    state_e         state_q, state_d;
    owner_e         owner_q, owner_d, pick;
    req_t           req_q, req_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           accept, timeout, rsp, err;
    logic [XLEN-1:0] rdata;
    arb_rr2 #(.LSU_PRIO(LSU_PRIO)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .ifu_v_i(bus.ifu_req_valid),
        .lsu_v_i(bus.lsu_req_valid),
        .en_i   (state_q == IDLE),
        .owner_o(pick),
        .gnt_o  (accept)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            req_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        timeout     = cnt_q == TO;
        state_d     = (state_q == IDLE) ? (accept ? REQ : IDLE) :
                      (state_q == REQ)  ? (bus.mem_req_ready ? WAIT : REQ) :
                      (bus.mem_rsp_valid || timeout) ? IDLE : WAIT;
        cnt_d       = (state_q != WAIT) ? '0 : (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        owner_d     = accept ? pick : owner_q;
        req_d       = req_q;
        req_d.addr  = !accept ? req_q.addr  : (pick == OWN_LSU) ? bus.lsu_req_addr  : bus.ifu_req_addr;
        req_d.wen   = !accept ? req_q.wen   : (pick == OWN_LSU) && bus.lsu_req_wen;
        req_d.wdata = !accept ? req_q.wdata : (pick == OWN_LSU) ? bus.lsu_req_wdata : '0;
        req_d.wmask = !accept ? req_q.wmask : (pick == OWN_LSU) ? bus.lsu_req_wmask : 4'hF;
    end
    // a real response in the timeout cycle wins over the error
    always_comb begin
        rsp               = state_q == WAIT && (bus.mem_rsp_valid || timeout);
        err               = rsp && !bus.mem_rsp_valid;
        rdata             = (rsp && bus.mem_rsp_valid) ? bus.mem_rsp_rdata : '0;
        bus.ifu_req_ready = accept && pick == OWN_IFU;
        bus.lsu_req_ready = accept && pick == OWN_LSU;
        bus.ifu_rsp_valid = rsp && owner_q == OWN_IFU;
        bus.lsu_rsp_valid = rsp && owner_q == OWN_LSU;
        bus.ifu_rsp_err   = err && owner_q == OWN_IFU;
        bus.lsu_rsp_err   = err && owner_q == OWN_LSU;
        bus.ifu_rsp_rdata = (owner_q == OWN_IFU) ? rdata : '0;
        bus.lsu_rsp_rdata = (owner_q == OWN_LSU) ? rdata : '0;
        bus.mem_req_valid = state_q == REQ;
        bus.mem_addr      = req_q.addr;
        bus.mem_wen       = req_q.wen;
        bus.mem_wdata     = req_q.wdata;
        bus.mem_wmask     = req_q.wmask;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of priority, round-robin, timeout, backpressure, reset
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    mem_arbiter_if bus_a ();
    mem_arbiter_if bus_b ();
    mem_arbiter #(.LSU_PRIO(1'b1), .TIMEOUT(8)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_arbiter #(.LSU_PRIO(1'b0), .TIMEOUT(8)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    initial begin
        bus_a.ifu_req_valid = 0; bus_a.ifu_req_addr = 0; bus_a.lsu_req_valid = 0;
        bus_a.lsu_req_addr = 0; bus_a.lsu_req_wen = 0; bus_a.lsu_req_wdata = 0;
        bus_a.lsu_req_wmask = 0; bus_a.mem_req_ready = 0; bus_a.mem_rsp_valid = 0;
        bus_a.mem_rsp_rdata = 0;
        bus_b.ifu_req_valid = 0; bus_b.ifu_req_addr = 0; bus_b.lsu_req_valid = 0;
        bus_b.lsu_req_addr = 0; bus_b.lsu_req_wen = 0; bus_b.lsu_req_wdata = 0;
        bus_b.lsu_req_wmask = 0; bus_b.mem_req_ready = 0; bus_b.mem_rsp_valid = 0;
        bus_b.mem_rsp_rdata = 0;
        tick; tick;
        chk("rst_mem_valid", bus_a.mem_req_valid, 0);
        chk("rst_ifu_ready", bus_a.ifu_req_ready, 0);
        chk("rst_lsu_ready", bus_a.lsu_req_ready, 0);
        chk("rst_mem_addr", bus_a.mem_addr, 0);
        chk("rst_mem_wmask", bus_a.mem_wmask, 0);
        chk("rst_ifu_rsp", bus_a.ifu_rsp_valid, 0);
        rst = 0;
        // single IFU read, minimum latency
        tick;
        bus_a.ifu_req_valid = 1; bus_a.ifu_req_addr = 32'h8000_0000; #1;
        chk("t1_ifu_ready", bus_a.ifu_req_ready, 1);
        chk("t1_lsu_ready", bus_a.lsu_req_ready, 0);
        tick;
        bus_a.ifu_req_valid = 0; bus_a.mem_req_ready = 1; #1;
        chk("t1_mem_valid", bus_a.mem_req_valid, 1);
        chk("t1_mem_addr", bus_a.mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", bus_a.mem_wen, 0);
        chk("t1_mem_wmask", bus_a.mem_wmask, 4'hF);
        tick;
        bus_a.mem_req_ready = 0; bus_a.mem_rsp_valid = 1; bus_a.mem_rsp_rdata = 32'h0000_0413; #1;
        chk("t1_ifu_rsp", bus_a.ifu_rsp_valid, 1);
        chk("t1_ifu_rdata", bus_a.ifu_rsp_rdata, 32'h0000_0413);
        chk("t1_ifu_err", bus_a.ifu_rsp_err, 0);
        chk("t1_lsu_rsp", bus_a.lsu_rsp_valid, 0);
        tick;
        bus_a.mem_rsp_valid = 0; #1;
        chk("t1_rsp_pulse", bus_a.ifu_rsp_valid, 0);
        // simultaneous requests with LSU priority
        bus_a.ifu_req_valid = 1; bus_a.ifu_req_addr = 32'h8000_0004;
        bus_a.lsu_req_valid = 1; bus_a.lsu_req_addr = 32'h8000_1000; bus_a.lsu_req_wen = 1;
        bus_a.lsu_req_wdata = 32'hDEAD_BEEF; bus_a.lsu_req_wmask = 4'b0011; #1;
        chk("t2_lsu_ready", bus_a.lsu_req_ready, 1);
        chk("t2_ifu_ready", bus_a.ifu_req_ready, 0);
        tick;
        bus_a.lsu_req_valid = 0; bus_a.lsu_req_wen = 0; bus_a.mem_req_ready = 1; #1;
        chk("t2_ifu_ready_req", bus_a.ifu_req_ready, 0);
        chk("t2_mem_addr", bus_a.mem_addr, 32'h8000_1000);
        chk("t2_mem_wen", bus_a.mem_wen, 1);
        chk("t2_mem_wdata", bus_a.mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_wmask", bus_a.mem_wmask, 4'b0011);
        tick;
        bus_a.mem_req_ready = 0; bus_a.mem_rsp_valid = 1; bus_a.mem_rsp_rdata = 0; #1;
        chk("t2_lsu_rsp", bus_a.lsu_rsp_valid, 1);
        chk("t2_ifu_rsp_early", bus_a.ifu_rsp_valid, 0);
        tick;
        bus_a.mem_rsp_valid = 0; #1;
        chk("t2_ifu_ready_next", bus_a.ifu_req_ready, 1);
        tick;
        bus_a.ifu_req_valid = 0; bus_a.mem_req_ready = 1; #1;
        chk("t2_mem_addr_ifu", bus_a.mem_addr, 32'h8000_0004);
        chk("t2_mem_wen_ifu", bus_a.mem_wen, 0);
        chk("t2_mem_wmask_ifu", bus_a.mem_wmask, 4'hF);
        tick;
        bus_a.mem_req_ready = 0; bus_a.mem_rsp_valid = 1; bus_a.mem_rsp_rdata = 32'h1234_5678; #1;
        chk("t2_ifu_rsp", bus_a.ifu_rsp_valid, 1);
        chk("t2_ifu_rdata", bus_a.ifu_rsp_rdata, 32'h1234_5678);
        tick;
        bus_a.mem_rsp_valid = 0;
        // backpressure then timeout
        bus_a.lsu_req_valid = 1; bus_a.lsu_req_addr = 32'h8000_2000;
        bus_a.lsu_req_wdata = 32'h0; bus_a.lsu_req_wmask = 4'b1100; #1;
        chk("t3_lsu_ready", bus_a.lsu_req_ready, 1);
        tick;
        bus_a.lsu_req_valid = 0; bus_a.mem_rsp_rdata = 32'hFFFF_FFFF; #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_mem_valid", bus_a.mem_req_valid, 1);
            chk("bp_mem_addr", bus_a.mem_addr, 32'h8000_2000);
            chk("bp_mem_wmask", bus_a.mem_wmask, 4'b1100);
            chk("bp_lsu_ready", bus_a.lsu_req_ready, 0);
            chk("bp_lsu_rsp", bus_a.lsu_rsp_valid, 0);
            tick;
        end
        bus_a.mem_req_ready = 1;
        tick;
        bus_a.mem_req_ready = 0;
        for (int i = 0; i < 8; i++) begin
            chk("to_early_rsp", bus_a.lsu_rsp_valid, 0);
            tick;
        end
        chk("to_rsp", bus_a.lsu_rsp_valid, 1);
        chk("to_err", bus_a.lsu_rsp_err, 1);
        chk("to_rdata", bus_a.lsu_rsp_rdata, 0);
        tick; tick;
        bus_a.mem_rsp_valid = 1; #1;
        chk("to_late_rsp", bus_a.lsu_rsp_valid, 0);
        chk("to_late_err", bus_a.lsu_rsp_err, 0);
        tick;
        bus_a.mem_rsp_valid = 0;
        // reset while in WAIT
        bus_a.ifu_req_valid = 1; bus_a.ifu_req_addr = 32'h8000_0010;
        tick;
        bus_a.ifu_req_valid = 0; bus_a.mem_req_ready = 1;
        tick;
        bus_a.mem_req_ready = 0; rst = 1;
        tick;
        rst = 0; bus_a.mem_rsp_valid = 1; bus_a.mem_rsp_rdata = 32'h55; #1;
        chk("rw_ifu_rsp", bus_a.ifu_rsp_valid, 0);
        chk("rw_mem_valid", bus_a.mem_req_valid, 0);
        chk("rw_mem_addr", bus_a.mem_addr, 0);
        chk("rw_mem_wmask", bus_a.mem_wmask, 0);
        tick;
        bus_a.mem_rsp_valid = 0; bus_a.ifu_req_valid = 1; bus_a.ifu_req_addr = 32'h8000_0020; #1;
        chk("rw_ifu_ready", bus_a.ifu_req_ready, 1);
        tick;
        bus_a.ifu_req_valid = 0; bus_a.mem_req_ready = 1; #1;
        chk("rw_mem_addr_new", bus_a.mem_addr, 32'h8000_0020);
        tick;
        bus_a.mem_req_ready = 0;
        for (int i = 0; i < 8; i++) tick;
        bus_a.mem_rsp_valid = 1; bus_a.mem_rsp_rdata = 32'hAA; #1;
        chk("edge_rsp", bus_a.ifu_rsp_valid, 1);
        chk("edge_err", bus_a.ifu_rsp_err, 0);
        chk("edge_rdata", bus_a.ifu_rsp_rdata, 32'hAA);
        tick;
        bus_a.mem_rsp_valid = 0;
        // round-robin with both requesters always valid
        bus_b.ifu_req_valid = 1; bus_b.ifu_req_addr = 32'h100;
        bus_b.lsu_req_valid = 1; bus_b.lsu_req_addr = 32'h200; #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ifu_ready", bus_b.ifu_req_ready, (k % 2) == 0);
            chk("rr_lsu_ready", bus_b.lsu_req_ready, (k % 2) == 1);
            tick;
            bus_b.mem_req_ready = 1; #1;
            chk("rr_mem_addr", bus_b.mem_addr, (k % 2) == 1 ? 32'h200 : 32'h100);
            tick;
            bus_b.mem_req_ready = 0; bus_b.mem_rsp_valid = 1; bus_b.mem_rsp_rdata = 32'(k); #1;
            chk("rr_lsu_rsp", bus_b.lsu_rsp_valid, (k % 2) == 1);
            tick;
            bus_b.mem_rsp_valid = 0; #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
